tl_rx_fc_credit_ctrl: RTL

Receive-side flow-control credit controller for the TL RX path. It converts released and received DW counts into scaled credit units, and keeps per-type CREDITS_ALLOCATED and CREDITS_RECEIVED counters for Posted, Non-Posted and Completion traffic. It detects receiver overflow and schedules UpdateFC requests toward the DLL through a valid/ready handshake. It sits between the RX TLP buffers (release and receive events) and the DLLP transmit scheduler.

---
 rtl/tl_rx_fc_credit_ctrl_pkg.sv | 45 ++++
 rtl/tl_rx_fc_credit_ctrl_if.sv | 16 +
 rtl/tl_rx_fc_dw2cred.sv | 22 ++
 rtl/tl_rx_fc_credit_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_rx_fc_credit_ctrl_pkg.sv
// Shared definitions for the TL RX flow-control credit controller:
// type and scale encodings, granule shifts and the scheduler state type.
package tl_rx_fc_pkg;

  localparam logic [1:0] FC_P   = 2'd0;
  localparam logic [1:0] FC_NP  = 2'd1;
  localparam logic [1:0] FC_CPL = 2'd2;

  localparam logic [1:0] SCALE_NONE = 2'b00;
  localparam logic [1:0] SCALE_1    = 2'b01;
  localparam logic [1:0] SCALE_4    = 2'b10;
  localparam logic [1:0] SCALE_16   = 2'b11;

  // data granule = 4/16/64 DW
  localparam logic [2:0] DATA_SHIFT_S1  = 3'd2;
  localparam logic [2:0] DATA_SHIFT_S4  = 3'd4;
  localparam logic [2:0] DATA_SHIFT_S16 = 3'd6;

  // header granule = 1/4/16 headers
  localparam logic [2:0] HDR_SHIFT_S1  = 3'd0;
  localparam logic [2:0] HDR_SHIFT_S4  = 3'd2;
  localparam logic [2:0] HDR_SHIFT_S16 = 3'd4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } upd_state_e;

  function automatic logic [2:0] data_shift(input logic [1:0] scale);
    case (scale)
      SCALE_4:  return DATA_SHIFT_S4;
      SCALE_16: return DATA_SHIFT_S16;
      default:  return DATA_SHIFT_S1;
    endcase
  endfunction

  function automatic logic [2:0] hdr_shift(input logic [1:0] scale);
    case (scale)
      SCALE_4:  return HDR_SHIFT_S4;
      SCALE_16: return HDR_SHIFT_S16;
      default:  return HDR_SHIFT_S1;
    endcase
  endfunction

endpackage

// File: rtl/tl_rx_fc_credit_ctrl_if.sv
// UpdateFC request channel from the credit controller to the DLLP scheduler.
interface tl_rx_fc_credit_ctrl_if #(
  parameter int HDR_FIELD_W  = 12,
  parameter int DATA_FIELD_W = 16
) ();
  logic                    upd_valid;
  logic                    upd_ready;
  logic [1:0]              upd_type;
  logic [HDR_FIELD_W-1:0]  upd_hdr_fc;
  logic [DATA_FIELD_W-1:0] upd_data_fc;

  modport master (output upd_valid, upd_type, upd_hdr_fc, upd_data_fc,
                  input  upd_ready);
  modport slave  (input  upd_valid, upd_type, upd_hdr_fc, upd_data_fc,
                  output upd_ready);
endinterface

// File: rtl/tl_rx_fc_dw2cred.sv
// DW count to data-credit conversion: ceil(dw / granule), granule set by scale.
module tl_rx_fc_dw2cred
  import tl_rx_fc_pkg::*;
#(
  parameter int PAYLOAD_LENGTH = 10
) (
  input  logic [1:0]                scale,
  input  logic [PAYLOAD_LENGTH-1:0] dw,
  output logic [PAYLOAD_LENGTH-1:0] creds
);
  localparam logic [PAYLOAD_LENGTH:0] ONE = (PAYLOAD_LENGTH+1)'(1);

  logic [2:0]              shift;
  logic [PAYLOAD_LENGTH:0] rounded;

  // round up by adding granule-1 before shifting; 0 DW stays 0
  always_comb begin
    shift   = data_shift(scale);
    rounded = {1'b0, dw} + ((ONE << shift) - ONE);
    creds   = PAYLOAD_LENGTH'(rounded >> shift);
  end
endmodule

// File: rtl/tl_rx_fc_credit_ctrl.sv
// Receive-side FC credit controller: per-type allocated/received counters,
// overflow detection and round-robin UpdateFC scheduling.
// Optional macro TL_RX_FC_UPD_TIMER_EN adds a periodic forced re-advertise.
//
// state   | meaning
// IDLE    | no request outstanding; pick next pending type round-robin
// REQ     | upd_valid high, latched fields held until upd_ready
module tl_rx_fc_credit_ctrl
  import tl_rx_fc_pkg::*;
#(
  parameter int NUM_TYPES        = 3,
  parameter int PAYLOAD_LENGTH   = 10,
  parameter int HDR_FIELD_W      = 12,
  parameter int DATA_FIELD_W     = 16,
  parameter int HDR_INIT_CREDS   = 32,
  parameter int DATA_INIT_CREDS  = 256,
  parameter int UPD_THRESH       = 8,
  parameter int UPD_TIMER_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic [2*NUM_TYPES-1:0]    cfg_hdr_scale,
  input  logic [2*NUM_TYPES-1:0]    cfg_data_scale,
  input  logic                      rx_valid,
  input  logic [1:0]                rx_type,
  input  logic [PAYLOAD_LENGTH-1:0] rx_dw,
  input  logic                      rel_valid,
  input  logic [1:0]                rel_type,
  input  logic [PAYLOAD_LENGTH-1:0] rel_dw,
  tl_rx_fc_credit_ctrl_if.master    upd,
  output logic                      overflow_err,
  output logic [1:0]                err_type
);
  localparam logic [HDR_FIELD_W-1:0]  HDR_INIT    = HDR_FIELD_W'(HDR_INIT_CREDS);
  localparam logic [DATA_FIELD_W-1:0] DATA_INIT   = DATA_FIELD_W'(DATA_INIT_CREDS);
  localparam logic [HDR_FIELD_W-1:0]  HDR_ONE     = HDR_FIELD_W'(1);
  localparam logic [HDR_FIELD_W-1:0]  HDR_THRESH  = HDR_FIELD_W'(UPD_THRESH);
  localparam logic [DATA_FIELD_W-1:0] DATA_THRESH = DATA_FIELD_W'(UPD_THRESH);

  logic [1:0]                rx_dscale, rel_dscale;
  logic [PAYLOAD_LENGTH-1:0] rx_creds, rel_creds;
  logic [3:0]                hdr_mask [NUM_TYPES];

  logic [HDR_FIELD_W-1:0]  alloc_hdr [NUM_TYPES], alloc_hdr_nxt [NUM_TYPES];
  logic [DATA_FIELD_W-1:0] alloc_data[NUM_TYPES], alloc_data_nxt[NUM_TYPES];
  logic [HDR_FIELD_W-1:0]  recv_hdr  [NUM_TYPES], recv_hdr_nxt  [NUM_TYPES];
  logic [DATA_FIELD_W-1:0] recv_data [NUM_TYPES], recv_data_nxt [NUM_TYPES];
  logic [3:0]              rel_res   [NUM_TYPES], rel_res_nxt   [NUM_TYPES];
  logic [3:0]              rx_res    [NUM_TYPES], rx_res_nxt    [NUM_TYPES];
  logic [HDR_FIELD_W-1:0]  adv_hdr   [NUM_TYPES];
  logic [DATA_FIELD_W-1:0] adv_data  [NUM_TYPES];

  logic [HDR_FIELD_W-1:0]  hdr_room;
  logic [DATA_FIELD_W-1:0] data_room;
  logic                    ovf_nxt;

  logic [NUM_TYPES-1:0] pend, force_q;
  upd_state_e           state, state_nxt;
  logic [1:0]           grant, last_q;
  logic                 grant_found, hs;
  int                   rr_idx;

  // per-event scale selection and header granule masks
  always_comb begin
    rx_dscale  = '0;
    rel_dscale = '0;
    for (int t = 0; t < NUM_TYPES; t++) begin
      if (rx_type == 2'(t))  rx_dscale  = cfg_data_scale[2*t +: 2];
      if (rel_type == 2'(t)) rel_dscale = cfg_data_scale[2*t +: 2];
      hdr_mask[t] = (4'd1 << hdr_shift(cfg_hdr_scale[2*t +: 2])) - 4'd1;
    end
  end

  tl_rx_fc_dw2cred #(.PAYLOAD_LENGTH(PAYLOAD_LENGTH)) u_rx_cvt (
    .scale(rx_dscale), .dw(rx_dw), .creds(rx_creds));

  tl_rx_fc_dw2cred #(.PAYLOAD_LENGTH(PAYLOAD_LENGTH)) u_rel_cvt (
    .scale(rel_dscale), .dw(rel_dw), .creds(rel_creds));

  // next counter values; header advances when the residue wraps
  always_comb begin
    for (int t = 0; t < NUM_TYPES; t++) begin
      alloc_hdr_nxt[t]  = alloc_hdr[t];
      alloc_data_nxt[t] = alloc_data[t];
      recv_hdr_nxt[t]   = recv_hdr[t];
      recv_data_nxt[t]  = recv_data[t];
      rel_res_nxt[t]    = rel_res[t];
      rx_res_nxt[t]     = rx_res[t];
      if (rel_valid && rel_type == 2'(t)) begin
        if (rel_res[t] == hdr_mask[t]) begin
          rel_res_nxt[t]   = '0;
          alloc_hdr_nxt[t] = alloc_hdr[t] + HDR_ONE;
        end else begin
          rel_res_nxt[t] = rel_res[t] + 4'd1;
        end
        alloc_data_nxt[t] = alloc_data[t] + DATA_FIELD_W'(rel_creds);
      end
      if (rx_valid && rx_type == 2'(t)) begin
        if (rx_res[t] == hdr_mask[t]) begin
          rx_res_nxt[t]   = '0;
          recv_hdr_nxt[t] = recv_hdr[t] + HDR_ONE;
        end else begin
          rx_res_nxt[t] = rx_res[t] + 4'd1;
        end
        recv_data_nxt[t] = recv_data[t] + DATA_FIELD_W'(rx_creds);
      end
    end
  end

  // overflow: post-update room has gone "negative" (MSB set)
  always_comb begin
    ovf_nxt   = 1'b0;
    hdr_room  = '0;
    data_room = '0;
    for (int t = 0; t < NUM_TYPES; t++) begin
      if (rx_valid && rx_type == 2'(t)) begin
        hdr_room  = alloc_hdr_nxt[t] - recv_hdr_nxt[t];
        data_room = alloc_data_nxt[t] - recv_data_nxt[t];
        ovf_nxt   = hdr_room[HDR_FIELD_W-1] | data_room[DATA_FIELD_W-1];
      end
    end
  end

  // counter registers; advertised copy taken on handshake
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int t = 0; t < NUM_TYPES; t++) begin
        alloc_hdr[t]  <= HDR_INIT;
        alloc_data[t] <= DATA_INIT;
        recv_hdr[t]   <= '0;
        recv_data[t]  <= '0;
        rel_res[t]    <= '0;
        rx_res[t]     <= '0;
        adv_hdr[t]    <= HDR_INIT;
        adv_data[t]   <= DATA_INIT;
      end
    end else begin
      for (int t = 0; t < NUM_TYPES; t++) begin
        alloc_hdr[t]  <= alloc_hdr_nxt[t];
        alloc_data[t] <= alloc_data_nxt[t];
        recv_hdr[t]   <= recv_hdr_nxt[t];
        recv_data[t]  <= recv_data_nxt[t];
        rel_res[t]    <= rel_res_nxt[t];
        rx_res[t]     <= rx_res_nxt[t];
      end
      if (hs) begin
        adv_hdr[upd.upd_type]  <= upd.upd_hdr_fc;
        adv_data[upd.upd_type] <= upd.upd_data_fc;
      end
    end
  end

  // overflow pulse register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      overflow_err <= 1'b0;
      err_type     <= '0;
    end else begin
      overflow_err <= ovf_nxt;
      if (ovf_nxt) err_type <= rx_type;
    end
  end

  // a type needs an UpdateFC once its un-advertised increment reaches threshold
  always_comb begin
    for (int t = 0; t < NUM_TYPES; t++) begin
      pend[t] = ((alloc_hdr[t] - adv_hdr[t]) >= HDR_THRESH) ||
                ((alloc_data[t] - adv_data[t]) >= DATA_THRESH) || force_q[t];
    end
  end

`ifdef TL_RX_FC_UPD_TIMER_EN
  localparam int TMR_W = (UPD_TIMER_CYCLES > 1) ? $clog2(UPD_TIMER_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(UPD_TIMER_CYCLES - 1);

  logic [TMR_W-1:0]     tmr_q;
  logic                 tmr_exp;
  logic [NUM_TYPES-1:0] clr_mask;

  assign tmr_exp  = (tmr_q == '0);
  assign clr_mask = hs ? (NUM_TYPES'(1) << upd.upd_type) : '0;

  // periodic timer; expiry forces a re-advertise of every type
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tmr_q   <= TMR_LOAD;
      force_q <= '0;
    end else begin
      tmr_q   <= tmr_exp ? TMR_LOAD : tmr_q - TMR_W'(1);
      force_q <= tmr_exp ? '1 : (force_q & ~clr_mask);
    end
  end
`else
  assign force_q = '0;
`endif

  assign hs            = upd.upd_valid && upd.upd_ready;
  assign upd.upd_valid = (state == ST_REQ);

  // scheduler state register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // round-robin grant starting after the last served type, next state
  always_comb begin
    state_nxt   = state;
    grant       = '0;
    grant_found = 1'b0;
    rr_idx      = 0;
    for (int k = 1; k <= NUM_TYPES; k++) begin
      rr_idx = (int'(last_q) + k) % NUM_TYPES;
      if (!grant_found && pend[rr_idx]) begin
        grant_found = 1'b1;
        grant       = 2'(rr_idx);
      end
    end
    case (state)
      ST_IDLE: if (grant_found)   state_nxt = ST_REQ;
      ST_REQ:  if (upd.upd_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // request fields are captured on entry to REQ and held through any stall
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      upd.upd_type    <= '0;
      upd.upd_hdr_fc  <= '0;
      upd.upd_data_fc <= '0;
      last_q          <= FC_CPL;
    end else if (state == ST_IDLE && grant_found) begin
      upd.upd_type    <= grant;
      upd.upd_hdr_fc  <= alloc_hdr[grant];
      upd.upd_data_fc <= alloc_data[grant];
      last_q          <= grant;
    end
  end
endmodule
